ram_burst_reader: RTL

//   Streams a contiguous block of words out of a RAM with a 1-cycle registered

---
 rtl/ram_burst_reader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Streams a contiguous block of RAM words to a valid/ready consumer.
// A 2-entry buffer absorbs the RAM's one-cycle read latency so a ready consumer gets one word per cycle.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iBaseAddr,
  input  logic [ADDR_WIDTH:0]   iLength,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  output logic                  oReadEnable,
  input  logic [DATA_WIDTH-1:0] iRamData,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oLast,
  output logic                  oBusy,
  output logic                  oDone
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     remaining_q;
  logic                    inflight_q;
  logic                    inflight_last_q;
  logic [1:0]              occ_q;
  logic [DATA_WIDTH-1:0]   data_q [2];
  logic                    last_q [2];

  logic                    pop;
  logic                    issue;
  logic                    drain_done;
  logic [2:0]              pending;

  always_comb begin
    pop        = (occ_q != 2'd0) && iReady;
    // Slots already committed after this cycle's transfer; a new issue needs one free.
    pending    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    issue      = (state_q == RUN) && (remaining_q != '0) && (pending < 3'd2);
    drain_done = (remaining_q == '0) && !inflight_q &&
                 ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      // NOTE: the buffer entries are reset as well because oData is driven straight from the head entry.
      data_q[0]       <= '0;
      data_q[1]       <= '0;
      last_q[0]       <= 1'b0;
      last_q[1]       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iStart) begin
            addr_q      <= iBaseAddr;
            remaining_q <= iLength;
            state_q     <= (iLength != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (issue) begin
            addr_q      <= addr_q + ADDR_ONE;
            remaining_q <= remaining_q - REM_ONE;
          end
          if (drain_done) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == REM_ONE);

      // Head is always entry 0; a pop shifts entry 1 forward.
      case ({inflight_q, pop})
        2'b01: begin
          data_q[0] <= data_q[1];
          last_q[0] <= last_q[1];
          occ_q     <= occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            data_q[0] <= iRamData;
            last_q[0] <= inflight_last_q;
          end else begin
            data_q[1] <= iRamData;
            last_q[1] <= inflight_last_q;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            data_q[0] <= data_q[1];
            last_q[0] <= last_q[1];
            data_q[1] <= iRamData;
            last_q[1] <= inflight_last_q;
          end else begin
            data_q[0] <= iRamData;
            last_q[0] <= inflight_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign oReadAddress = addr_q;
  assign oReadEnable  = issue;
  assign oValid       = (occ_q != 2'd0);
  assign oData        = data_q[0];
  assign oLast        = last_q[0] && oValid;
  assign oDone        = (state_q == DONE);
  assign oBusy        = (state_q != IDLE) && !oDone;

endmodule
